// File: rtl/edge_event_gen_pkg.sv
// ============================================================================
// Module  : edge_event_gen_pkg
// Brief   : Types and level helpers shared by the edge event generator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package edge_event_gen_pkg;

   typedef enum logic [1:0] {
      POSEDGE = 2'd0,
      NEGEDGE = 2'd1,
      EDGE    = 2'd2,
      NONE    = 2'd3
   } edge_kind_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      ARM   = 2'd2,
      FIRE  = 2'd3
   } gen_state_e;

   // Level placed on the line one cycle before the event so the event edge always occurs.
   function automatic logic pre_level(edge_kind_e kind, logic cur);
      case (kind)
         POSEDGE: return 1'b0;
         NEGEDGE: return 1'b1;
         default: return cur;
      endcase
   endfunction

   function automatic logic target_level(edge_kind_e kind, logic cur);
      case (kind)
         POSEDGE: return 1'b1;
         NEGEDGE: return 1'b0;
         EDGE:    return ~cur;
         default: return cur;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_gen_delay_ctr.sv
// ============================================================================
// Module  : edge_event_gen_delay_ctr
// Brief   : Loadable down-counter with zero flag, paces the DELAY phase.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module edge_event_gen_delay_ctr #(
   parameter int DELAY_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [DELAY_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [DELAY_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DELAY_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/edge_event_gen.sv
// ============================================================================
// Module  : edge_event_gen
// Brief   : Generates N posedge/negedge/any-edge events, each after a delay.
//           Optional abort port pair enabled by EDGE_EVENT_GEN_ABORT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module edge_event_gen
   import edge_event_gen_pkg::*;
#(
   parameter int   DELAY_W    = 8,
   parameter int   COUNT_W    = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_kind,
   input  logic [DELAY_W-1:0] req_delay,
   input  logic [COUNT_W-1:0] req_count,
   input  logic               iff_en,
`ifdef EDGE_EVENT_GEN_ABORT_EN
   input  logic               abort,
   output logic               aborted,
`endif
   output logic               ev_out,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] ev_count
);

   gen_state_e         state_q, state_d;
   edge_kind_e         kind_q, kind_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [COUNT_W-1:0] rem_q, rem_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               ev_q, ev_d;
   logic               done_q, done_d;
   logic               pend_q, pend_d;
`ifdef EDGE_EVENT_GEN_ABORT_EN
   logic               aborted_q, aborted_d;
`endif

   logic               accept;
   logic               ctr_load;
   logic               ctr_dec;
   logic [DELAY_W-1:0] ctr_val;
   logic               ctr_zero;

   // Counter holds delay-1 so that zero marks the final DELAY cycle.
   edge_event_gen_delay_ctr #(
      .DELAY_W (DELAY_W)
   ) u_delay_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ctr_load),
      .load_val_i (ctr_val),
      .dec_i      (ctr_dec),
      .zero_o     (ctr_zero)
   );

   // A pending or visible done pulse blocks acceptance so done never overlaps a new request.
   assign req_ready = (state_q == IDLE) && !done_q && !pend_q;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      delay_d  = delay_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      ev_d     = ev_q;
      done_d   = 1'b0;
      pend_d   = 1'b0;
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      ctr_val  = delay_q - DELAY_W'(1);
`ifdef EDGE_EVENT_GEN_ABORT_EN
      aborted_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               done_d = 1'b1;
            end
            if (accept) begin
               kind_d  = edge_kind_e'(req_kind);
               delay_d = req_delay;
               rem_d   = req_count;
               cnt_d   = '0;
               if ((req_count == '0) || (edge_kind_e'(req_kind) == NONE)) begin
                  pend_d = 1'b1;
               end else if (req_delay != '0) begin
                  state_d  = DELAY;
                  ctr_load = 1'b1;
                  ctr_val  = req_delay - DELAY_W'(1);
               end else begin
                  state_d = ARM;
               end
            end
         end
         DELAY: begin
            if (ctr_zero) begin
               state_d = ARM;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ARM: begin
            ev_d    = pre_level(kind_q, ev_q);
            state_d = FIRE;
         end
         FIRE: begin
            if (iff_en) begin
               ev_d  = target_level(kind_q, ev_q);
               cnt_d = cnt_q + COUNT_W'(1);
               rem_d = rem_q - COUNT_W'(1);
               if (rem_q == COUNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (delay_q != '0) begin
                  state_d  = DELAY;
                  ctr_load = 1'b1;
               end else begin
                  state_d = ARM;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef EDGE_EVENT_GEN_ABORT_EN
      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         ev_d      = ev_q;
         cnt_d     = cnt_q;
         done_d    = 1'b1;
         aborted_d = 1'b1;
         ctr_load  = 1'b0;
         ctr_dec   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= POSEDGE;
         delay_q <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         ev_q    <= IDLE_LEVEL;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         delay_q <= delay_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         ev_q    <= ev_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
      end
   end

`ifdef EDGE_EVENT_GEN_ABORT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= aborted_d;
      end
   end

   assign aborted = aborted_q;
`endif

   assign ev_out   = ev_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign ev_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_gen.sv
// ============================================================================
// Module  : tb_edge_event_gen
// Brief   : Scoreboard bench: stimulus queues timed edge/done expectations,
//           a negedge monitor pops and compares every observed change.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_edge_event_gen;

   localparam int DELAY_W = 8;
   localparam int COUNT_W = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [1:0]         req_kind = 2'd0;
   logic [DELAY_W-1:0] req_delay = '0;
   logic [COUNT_W-1:0] req_count = '0;
   logic               iff_en = 1'b1;
   logic               ev_out;
   logic               busy;
   logic               done;
   logic [COUNT_W-1:0] ev_count;
`ifdef EDGE_EVENT_GEN_ABORT_EN
   logic               abort = 1'b0;
   logic               aborted;
`endif

   edge_event_gen #(
      .DELAY_W    (DELAY_W),
      .COUNT_W    (COUNT_W),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_kind  (req_kind),
      .req_delay (req_delay),
      .req_count (req_count),
      .iff_en    (iff_en),
`ifdef EDGE_EVENT_GEN_ABORT_EN
      .abort     (abort),
      .aborted   (aborted),
`endif
      .ev_out    (ev_out),
      .busy      (busy),
      .done      (done),
      .ev_count  (ev_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit is_done;
      int val;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_ev = 1'b0;
   logic lvl = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int v);
      exp_t e;
      e.cyc = c; e.is_done = 1'b0; e.val = v;
      q.push_back(e);
   endtask

   task automatic push_done(input int c, input int n);
      exp_t e;
      e.cyc = c; e.is_done = 1'b1; e.val = n;
      q.push_back(e);
   endtask

   task automatic observe(input bit is_done, input int val);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got value %0d expected nothing (cycle %0d)",
                  is_done ? "done" : "edge", val, cyc);
      end else begin
         e = q.pop_front();
         chk(is_done ? "done_kind" : "edge_kind", int'(is_done), int'(e.is_done));
         chk(is_done ? "done_cycle" : "edge_cycle", cyc, e.cyc);
         chk(is_done ? "done_ev_count" : "edge_level", val, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ev = ev_out;
      end else begin
         if (ev_out !== prev_ev) begin
            observe(1'b0, int'(ev_out));
            prev_ev = ev_out;
         end
         if (done) begin
            observe(1'b1, int'(ev_count));
            chk("ready_low_during_done", int'(req_ready), 0);
            chk("busy_low_during_done", int'(busy), 0);
         end
      end
   end

   // Expected timeline: event k lands at e0 + k*(d+2), its pre-level one edge earlier.
   task automatic expect_run(input int kind, input int d, input int c, input int e0);
      logic pre, tgt;
      int   t;
      if (c == 0 || kind == 3) begin
         push_done(e0 + 1, 0);
      end else begin
         for (int k = 1; k <= c; k++) begin
            t   = e0 + k * (d + 2);
            pre = (kind == 0) ? 1'b0 : (kind == 1) ? 1'b1 : lvl;
            if (pre != lvl) push_ev(t - 1, int'(pre));
            lvl = pre;
            tgt = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : ~lvl;
            push_ev(t, int'(tgt));
            lvl = tgt;
         end
         push_done(e0 + c * (d + 2), c);
      end
   endtask

   task automatic issue(input int kind, input int d, input int c, output int e0);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 0, 1);
      req_kind  = 2'(kind);
      req_delay = DELAY_W'(d);
      req_count = COUNT_W'(c);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
   endtask

   int e0;

   initial begin
      #1;
      chk("reset_ev_out", int'(ev_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ev_count", int'(ev_count), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", int'(req_ready), 1);

      // POSEDGE d=3 n=4 from idle 0
      issue(0, 3, 4, e0);
      expect_run(0, 3, 4, e0);
      wait_quiet();
      chk("posedge_final_level", int'(ev_out), 1);

      // NEGEDGE d=0 n=2 from level 1
      issue(1, 0, 2, e0);
      expect_run(1, 0, 2, e0);
      wait_quiet();

      // EDGE d=1 n=3 from level 0
      issue(2, 1, 3, e0);
      expect_run(2, 1, 3, e0);
      wait_quiet();
      chk("edge_final_level", int'(ev_out), 1);
      chk("edge_final_count", int'(ev_count), 3);

      // count=0, then kind=NONE: done only, never busy
      issue(0, 2, 0, e0);
      expect_run(0, 2, 0, e0);
      chk("count0_busy", int'(busy), 0);
      wait_quiet();
      issue(3, 1, 3, e0);
      expect_run(3, 1, 3, e0);
      chk("none_busy", int'(busy), 0);
      wait_quiet();
      chk("none_level_kept", int'(ev_out), 1);

      // POSEDGE d=2 n=2 with iff_en low for 7 edges during the first FIRE
      iff_en = 1'b0;
      issue(0, 2, 2, e0);
      push_ev(e0 + 3, 0);
      push_ev(e0 + 11, 1);
      push_ev(e0 + 14, 0);
      push_ev(e0 + 15, 1);
      push_done(e0 + 15, 2);
      while (cyc < e0 + 10) @(negedge clk);
      chk("stall_busy", int'(busy), 1);
      chk("stall_count", int'(ev_count), 0);
      iff_en = 1'b1;
      wait_quiet();
      lvl = 1'b1;

      // reset in DELAY of a count=5 request
      issue(0, 5, 5, e0);
      while (cyc < e0 + 2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_ev_out", int'(ev_out), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_ev_count", int'(ev_count), 0);
      @(negedge clk);
      #2;
      rst_n     = 1'b1;
      lvl       = 1'b0;
      req_kind  = 2'd1;
      req_delay = '0;
      req_count = COUNT_W'(1);
      req_valid = 1'b1;
      #1;
      chk("ready_after_midreset", int'(req_ready), 1);
      @(posedge clk);
      #1;
      e0 = cyc;
      req_valid = 1'b0;
      chk("accept_after_midreset", int'(busy), 1);
      expect_run(1, 0, 1, e0);
      wait_quiet();
      chk("post_reset_count", int'(ev_count), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
